// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: owns the register-file write port, merges ALU and long-latency results
module reg_writeback_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int QDEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         AluValid,
    input  logic [ADDR_W-1:0]            AluRegister,
    input  logic [DATA_W-1:0]            AluData,
    input  logic                         LongIssue,
    input  logic [ADDR_W-1:0]            LongIssueRegister,
    input  logic                         LongValid,
    output logic                         LongReady,
    input  logic [ADDR_W-1:0]            LongRegister,
    input  logic [DATA_W-1:0]            LongData,
    output logic                         RegisterWrite,
    output logic [ADDR_W-1:0]            WriteRegister,
    output logic [DATA_W-1:0]            WriteData,
    output logic [2**ADDR_W-1:0]         Pending,
    output logic [$clog2(QDEPTH):0]      QueueCount
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    logic [ADDR_W-1:0]    q_reg  [QDEPTH];
    logic [DATA_W-1:0]    q_data [QDEPTH];
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic                 alu_sel, push, pop;
    logic [2**ADDR_W-1:0] pend_nxt;

    assign LongReady = QueueCount < FULL;
    assign alu_sel   = AluValid && AluRegister != '0;
    // register-0 results complete the handshake but never occupy a slot
    assign push      = LongValid && LongReady && LongRegister != '0;
    assign pop       = !alu_sel && QueueCount != '0;

    // a same-edge set overrides the clear from the popped entry
    always_comb begin
        pend_nxt = Pending;
        if (pop)
            pend_nxt[q_reg[rd_ptr]] = 1'b0;
        if (LongIssue)
            pend_nxt[LongIssueRegister] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_reg[wr_ptr]  <= LongRegister;
            q_data[wr_ptr] <= LongData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegisterWrite <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            Pending       <= '0;
            QueueCount    <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
        end else begin
            RegisterWrite <= alu_sel || pop;
            if (alu_sel) begin
                WriteRegister <= AluRegister;
                WriteData     <= AluData;
            end else if (pop) begin
                WriteRegister <= q_reg[rd_ptr];
                WriteData     <= q_data[rd_ptr];
            end
            Pending    <= pend_nxt;
            QueueCount <= QueueCount + CW'(push) - CW'(pop);
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end
endmodule
